// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3 absorb sequencer: variant modes,
// rate-block sizes and the padding byte values.
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_mode_e;

  typedef enum logic [1:0] {
    ST_ABSORB = 2'd0,
    ST_PAD    = 2'd1,
    ST_PERM   = 2'd2
  } seq_state_e;

  // What the word on m_tdata is made of.
  typedef enum logic [1:0] {
    PK_DATA      = 2'd0,
    PK_LAST      = 2'd1,
    PK_PAD_FIRST = 2'd2,
    PK_PAD_MID   = 2'd3
  } pad_kind_e;

  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  // Rate in 16-bit words: (1600 - 2*digest_bits) / 16.
  function automatic logic [6:0] rate_words(input sha3_mode_e mode);
    case (mode)
      SHA3_224: return 7'd72;
      SHA3_256: return 7'd68;
      SHA3_384: return 7'd52;
      default:  return 7'd36;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Builds the word handed to the absorb datapath: message data, a partially
// padded last word, or a generated pad word, with 0x80 merged at the block end.
module sha3_pad_word
  import sha3_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W-1:0] rate,
  input  pad_kind_e        kind,
  input  logic [15:0]      data,
  input  logic [1:0]       tkeep,
  output logic [15:0]      word
);

  logic       is_end;
  logic [7:0] end_byte;

  assign is_end   = (idx == rate - IDX_W'(1));
  assign end_byte = is_end ? PAD_LAST : 8'h00;

  always_comb begin
    word = data;
    case (kind)
      PK_LAST: begin
        case (tkeep)
          2'b01:   word = {PAD_FIRST | end_byte, data[7:0]};
          2'b00:   word = {end_byte, PAD_FIRST};
          default: word = data;
        endcase
      end
      PK_PAD_FIRST: word = {end_byte, PAD_FIRST};
      PK_PAD_MID:   word = {end_byte, 8'h00};
      default:      word = data;
    endcase
  end

endmodule

// File: rtl/sha3_absorb_sequencer.sv
// Streams message words into the Keccak absorb datapath, counts rate-block
// words, appends SHA3 padding and sequences permutation and squeeze starts.
module sha3_absorb_sequencer
  import sha3_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 7
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [1:0]       s_tkeep,
  input  logic [1:0]       s_tuser,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [IDX_W-1:0] m_idx,
  output logic             perm_start,
  input  logic             perm_done,
  output logic             sq_start,
  output logic [1:0]       sq_mode
);

  if (WIDTH != 16) begin : g_width_chk
    $error("sha3_absorb_sequencer: only WIDTH=16 is supported");
  end
  if (IDX_W < 7) begin : g_idx_chk
    $error("sha3_absorb_sequencer: IDX_W must be at least 7");
  end

  seq_state_e       state;
  sha3_mode_e       mode;
  sha3_mode_e       cur_mode;
  pad_kind_e        kind;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rate;
  logic [WIDTH-1:0] pad_word;
  logic             first, fin, padpend, pfirst, active;
  logic             at_end, hs;

  // The first word of a message is sized by its own s_tuser before mode latches.
  assign cur_mode = (state == ST_ABSORB && first) ? sha3_mode_e'(s_tuser) : mode;
  assign rate     = IDX_W'(rate_words(cur_mode));
  assign at_end   = (idx == rate - IDX_W'(1));
  assign m_idx    = idx;

  sha3_pad_word #(.IDX_W(IDX_W)) u_pad (
    .idx  (idx),
    .rate (rate),
    .kind (kind),
    .data (s_tdata),
    .tkeep(s_tkeep),
    .word (pad_word)
  );

  // active holds the pass-through path quiet while in and just out of reset.
  always_comb begin
    m_tvalid = 1'b0;
    s_tready = 1'b0;
    kind     = PK_DATA;
    if (active) begin
      case (state)
        ST_ABSORB: begin
          m_tvalid = s_tvalid;
          s_tready = m_tready;
          kind     = s_tlast ? PK_LAST : PK_DATA;
        end
        ST_PAD: begin
          m_tvalid = 1'b1;
          kind     = pfirst ? PK_PAD_FIRST : PK_PAD_MID;
        end
        default: ;
      endcase
    end
    m_tdata = (active && state != ST_PERM) ? pad_word : '0;
  end

  assign hs = m_tvalid && m_tready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= ST_ABSORB;
      mode       <= SHA3_224;
      idx        <= '0;
      first      <= 1'b1;
      fin        <= 1'b0;
      padpend    <= 1'b0;
      pfirst     <= 1'b0;
      active     <= 1'b0;
      perm_start <= 1'b0;
      sq_start   <= 1'b0;
      sq_mode    <= 2'd0;
    end else begin
      active     <= 1'b1;
      perm_start <= 1'b0;
      sq_start   <= 1'b0;
      case (state)
        ST_ABSORB: if (hs) begin
          if (first) begin
            mode  <= sha3_mode_e'(s_tuser);
            first <= 1'b0;
          end
          // A partial last word already carries the 0x06 byte.
          if (s_tlast && !s_tkeep[1]) fin <= 1'b1;
          if (at_end) begin
            state      <= ST_PERM;
            perm_start <= 1'b1;
            idx        <= '0;
            if (s_tlast && s_tkeep[1]) padpend <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
            if (s_tlast) begin
              state  <= ST_PAD;
              pfirst <= s_tkeep[1];
            end
          end
        end
        ST_PAD: if (hs) begin
          pfirst <= 1'b0;
          if (at_end) begin
            fin        <= 1'b1;
            state      <= ST_PERM;
            perm_start <= 1'b1;
            idx        <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_PERM: if (perm_done) begin
          if (fin) begin
            sq_start <= 1'b1;
            sq_mode  <= mode;
            fin      <= 1'b0;
            first    <= 1'b1;
            state    <= ST_ABSORB;
          end else if (padpend) begin
            padpend <= 1'b0;
            pfirst  <= 1'b1;
            state   <= ST_PAD;
          end else begin
            state <= ST_ABSORB;
          end
        end
        default: state <= ST_ABSORB;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_absorb_sequencer.sv
// Random-stimulus bench: messages are padded in a byte-level reference model
// and the absorbed word stream, block starts and squeeze starts are compared.
module tb_sha3_absorb_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [1:0]  s_tkeep = '0;
  logic [1:0]  s_tuser = '0;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [6:0]  m_idx;
  logic        perm_start;
  logic        perm_done = 1'b0;
  logic        sq_start;
  logic [1:0]  sq_mode;

  sha3_absorb_sequencer dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_idx(m_idx),
    .perm_start(perm_start), .perm_done(perm_done),
    .sq_start(sq_start), .sq_mode(sq_mode)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [1:0]  keep;
    logic [1:0]  user;
  } src_t;

  src_t        src_q[$];
  logic [15:0] exp_w[$], obs_w[$];
  int          exp_i[$], obs_i[$];
  bit          exp_last[$];
  int          exp_sq[$], obs_sq[$];
  int          exp_perm = 0, obs_perm = 0;
  int          checks = 0, failures = 0;
  int          viol_tready = 0, viol_stall = 0, viol_lat = 0;
  int          rdy_rand = 0, spur_en = 0;
  bit          accepted = 0, lat_pend = 0, stall_pend = 0;
  logic [15:0] stall_d;
  logic [6:0]  stall_i;
  int          pos;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rate_of(input int m);
    case (m)
      0: return 72;
      1: return 68;
      2: return 52;
      default: return 36;
    endcase
  endfunction

  // Reference: byte stream || 0x06 || 0x00.. with 0x80 in the last byte of the last block.
  task automatic send_msg(input int mode, input int nbytes, input int rest_user);
    int r, nw, blocks, plen;
    byte unsigned msg[];
    byte unsigned pad[];
    src_t w;
    r = rate_of(mode);
    msg = new[nbytes > 0 ? nbytes : 1];
    foreach (msg[i]) msg[i] = 8'($urandom);
    nw = (nbytes == 0) ? 1 : (nbytes + 1) / 2;
    for (int k = 0; k < nw; k++) begin
      w.data[7:0]  = (2*k < nbytes) ? msg[2*k] : 8'($urandom);
      w.data[15:8] = (2*k+1 < nbytes) ? msg[2*k+1] : 8'($urandom);
      w.last = (k == nw - 1);
      w.keep = !w.last ? 2'($urandom) : (nbytes == 0) ? 2'b00 : (nbytes % 2 == 1) ? 2'b01 : 2'b11;
      w.user = (k == 0) ? 2'(mode) : (rest_user < 0) ? 2'($urandom) : 2'(rest_user);
      src_q.push_back(w);
    end
    blocks = nbytes / (2*r) + 1;
    plen = blocks * 2 * r;
    pad = new[plen];
    foreach (pad[i]) pad[i] = 8'h00;
    for (int i = 0; i < nbytes; i++) pad[i] = msg[i];
    pad[nbytes] = pad[nbytes] | 8'h06;
    pad[plen-1] = pad[plen-1] | 8'h80;
    for (int i = 0; i < plen / 2; i++) begin
      exp_w.push_back({pad[2*i+1], pad[2*i]});
      exp_i.push_back(i % r);
      exp_last.push_back((i % r) == r - 1);
    end
    exp_perm += blocks;
    exp_sq.push_back(mode);
  endtask

  task automatic clear_sb();
    exp_w.delete(); obs_w.delete(); exp_i.delete(); obs_i.delete();
    exp_last.delete(); exp_sq.delete(); obs_sq.delete();
    exp_perm = 0; obs_perm = 0;
    viol_tready = 0; viol_stall = 0; viol_lat = 0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    int f0;
    while ((obs_sq.size() < exp_sq.size() || src_q.size() > 0) && cyc < 20000) begin
      @(posedge ACLK);
      cyc++;
    end
    repeat (10) @(posedge ACLK);
    @(negedge ACLK); #1;
    check({tag, "_sq_cnt"}, obs_sq.size(), exp_sq.size());
    for (int i = 0; i < exp_sq.size() && i < obs_sq.size(); i++)
      check({tag, "_sq_mode"}, obs_sq[i], exp_sq[i]);
    check({tag, "_nwords"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      f0 = failures;
      check($sformatf("%s_word%0d", tag, i), obs_w[i], exp_w[i]);
      check($sformatf("%s_idx%0d", tag, i), obs_i[i], exp_i[i]);
      if (failures != f0) break;
    end
    check({tag, "_perm_cnt"}, obs_perm, exp_perm);
    check({tag, "_s_tready_viol"}, viol_tready, 0);
    check({tag, "_stall_viol"}, viol_stall, 0);
    check({tag, "_perm_latency_viol"}, viol_lat, 0);
    clear_sb();
  endtask

  // Source driver: holds a word until accepted, random idle gaps between words.
  always begin
    bit popped;
    @(posedge ACLK); #1;
    popped = 0;
    if (accepted && src_q.size() > 0) begin
      void'(src_q.pop_front());
      popped = 1;
    end
    accepted = 0;
    if (src_q.size() > 0 && ((s_tvalid && !popped) || $urandom_range(0, 3) != 0)) begin
      s_tvalid = 1'b1;
      s_tdata  = src_q[0].data;
      s_tlast  = src_q[0].last;
      s_tkeep  = src_q[0].keep;
      s_tuser  = src_q[0].user;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = 16'($urandom);
      s_tlast  = 1'($urandom);
    end
  end

  always begin
    @(posedge ACLK); #1;
    m_tready = (rdy_rand != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Permutation core stand-in, with optional stray perm_done pulses.
  always begin
    @(negedge ACLK);
    if (perm_start) begin
      repeat ($urandom_range(0, 4)) @(posedge ACLK);
      @(posedge ACLK); #1 perm_done = 1'b1;
      @(posedge ACLK); #1 perm_done = 1'b0;
    end else if (spur_en != 0 && $urandom_range(0, 19) == 0) begin
      @(posedge ACLK); #1 perm_done = 1'b1;
      @(posedge ACLK); #1 perm_done = 1'b0;
    end
  end

  always begin
    @(negedge ACLK);
    if (ARESETn) begin
      accepted = s_tvalid && s_tready;
      if (s_tready && (!m_tready || s_tvalid !== m_tvalid)) viol_tready++;
      if (lat_pend && !perm_start) viol_lat++;
      lat_pend = 0;
      if (stall_pend && !(m_tvalid && m_tdata === stall_d && m_idx === stall_i)) viol_stall++;
      stall_pend = m_tvalid && !m_tready;
      stall_d = m_tdata;
      stall_i = m_idx;
      if (m_tvalid && m_tready) begin
        pos = obs_w.size();
        if (pos < exp_last.size() && exp_last[pos]) lat_pend = 1;
        obs_w.push_back(m_tdata);
        obs_i.push_back(int'(m_idx));
      end
      if (perm_start) obs_perm++;
      if (sq_start) obs_sq.push_back(int'(sq_mode));
    end else begin
      accepted = 0;
      lat_pend = 0;
      stall_pend = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit found;
    s_tvalid = 1'b1;
    #3;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_idx", m_idx, 0);
    check("rst_perm_start", perm_start, 0);
    check("rst_sq_start", sq_start, 0);
    check("rst_sq_mode", sq_mode, 0);
    repeat (3) @(posedge ACLK);
    #2 ARESETn = 1'b1;

    send_msg(1, 0, -1);
    wait_done("empty_m1");
    send_msg(3, 71, -1);
    wait_done("odd_m3");
    send_msg(3, 72, -1);
    wait_done("full_block_m3");
    send_msg(2, 103, -1);
    send_msg(1, 134, -1);
    send_msg(0, 143, -1);
    wait_done("block_edge");
    send_msg(3, 50, 0);
    send_msg(1, 9, -1);
    wait_done("tuser_toggle");

    rdy_rand = 1;
    spur_en = 1;
    send_msg(0, 400, -1);
    for (int k = 0; k < 5; k++) send_msg($urandom_range(0, 3), $urandom_range(0, 300), -1);
    wait_done("random");
    rdy_rand = 0;
    spur_en = 0;

    // Reset while generating pad words at idx 20 of a mode2 block.
    send_msg(2, 40, -1);
    cyc = 0;
    found = 0;
    while (!found && cyc < 3000) begin
      @(negedge ACLK); #1;
      found = m_tvalid && m_tready && !s_tready && (m_idx == 7'd20);
      cyc++;
    end
    check("mid_rst_reach_pad", found, 1);
    #1 ARESETn = 1'b0;
    #1;
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_m_tdata", m_tdata, 0);
    check("mid_rst_m_idx", m_idx, 0);
    check("mid_rst_perm_start", perm_start, 0);
    check("mid_rst_sq_start", sq_start, 0);
    src_q.delete();
    s_tvalid = 1'b0;
    accepted = 0;
    clear_sb();
    repeat (2) @(posedge ACLK);
    #2 ARESETn = 1'b1;
    send_msg(2, 2, -1);
    wait_done("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
